// File: rtl/data_mem_mmio.sv
// Data memory for the M stage: word RAM plus an MMIO page holding a free-running
// cycle counter and a first-word-fall-through TX FIFO drained over valid/ready.
module data_mem_mmio #(
    parameter int          ADDR_W     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0] OFF_CYCLE  = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;

    logic [31:0] ram [0:(1 << ADDR_W) - 1];
    logic [31:0] fifo_mem [0:FIFO_DEPTH - 1];

    logic [31:0]      cycle_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;

    logic              is_mmio;
    logic [15:0]       offset;
    logic [ADDR_W-1:0] ram_idx;
    logic              sel_txdata;
    logic              sel_status;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [31:0]       status_word;

    assign is_mmio    = (addr[31:16] == MMIO_TAG);
    assign offset     = addr[15:0];
    assign ram_idx    = addr[ADDR_W+1:2];
    assign sel_txdata = is_mmio && (offset == OFF_TXDATA);
    assign sel_status = is_mmio && (offset == OFF_STATUS);

    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign tx_valid = (count_reg != '0);
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = memwrite && sel_txdata && (!full || pop);
    assign drop     = memwrite && sel_txdata && full && !pop;

    assign tx_data     = fifo_mem[rd_ptr_reg];
    assign tx_overflow = overflow_reg;
    assign status_word = {22'b0, overflow_reg, full, 8'(count_reg)};

    always_comb begin
        rdata = 32'h0;
        if (is_mmio) begin
            case (offset)
                OFF_CYCLE:  rdata = cycle_reg;
                OFF_STATUS: rdata = status_word;
                default:    rdata = 32'h0;
            endcase
        end else begin
            rdata = ram[ram_idx];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage arrays carry no reset; queued words become unreachable once count clears.
    always_ff @(posedge clk) begin
        if (memwrite && !is_mmio) begin
            ram[ram_idx] <= wdata;
        end
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_reg    <= 32'h0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (memwrite && sel_status && wdata[9]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus a randomized run
// against a queue/array reference model of the memory, counter and TX FIFO.
module tb_data_mem_mmio;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_overflow;

    int checks;
    int failures;

    data_mem_mmio #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .MMIO_TAG(16'hFFFF)) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_overflow(tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [0:(1 << ADDR_W) - 1];
    bit          m_known [0:(1 << ADDR_W) - 1];
    logic [31:0] m_q [$];
    logic        m_ovf;
    logic [31:0] m_cycle;

    // Samples taken just before the active edge, and the model's expectations for them
    logic [31:0] s_rdata, s_data, e_rdata, e_head;
    logic        s_valid, s_ovf, e_valid, e_ovf, e_known;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:16] == 16'hFFFF) begin
            if (a[15:0] == 16'h0000) return m_cycle;
            if (a[15:0] == 16'h0008)
                return {22'b0, m_ovf, (m_q.size() == DEPTH), 8'(m_q.size())};
            return 32'h0;
        end
        return m_ram[a[ADDR_W+1:2]];
    endfunction

    // One bus cycle: drive at the falling edge, sample, advance the model, cross the rising edge.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        int  n;
        bit  was_full, do_pop;
        memwrite = we;
        addr     = a;
        wdata    = d;
        tx_ready = rdy;
        #1;
        s_rdata = rdata;
        s_valid = tx_valid;
        s_data  = tx_data;
        s_ovf   = tx_overflow;
        e_rdata = model_read(a);
        e_known = (a[31:16] == 16'hFFFF) || m_known[a[ADDR_W+1:2]];
        n       = m_q.size();
        e_valid = (n != 0);
        e_head  = (n != 0) ? m_q[0] : 32'h0;
        e_ovf   = m_ovf;
        $display("txn t=%0t we=%0b addr=%08h wdata=%08h rdy=%0b rdata=%08h valid=%0b data=%08h ovf=%0b",
                 $time, we, a, d, rdy, s_rdata, s_valid, s_data, s_ovf);
        was_full = (n == DEPTH);
        do_pop   = (n != 0) && rdy;
        if (we && a[31:16] != 16'hFFFF) begin
            m_ram[a[ADDR_W+1:2]]   = d;
            m_known[a[ADDR_W+1:2]] = 1'b1;
        end
        if (do_pop) void'(m_q.pop_front());
        if (we && a == 32'hFFFF0004) begin
            if (!was_full || do_pop) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        if (we && a == 32'hFFFF0008 && d[9]) m_ovf = 1'b0;
        m_cycle = m_cycle + 32'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        addr = 32'hFFFF0000;
        #1;
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_cycle got=%08h exp=%08h", rdata, 32'h0); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", tx_valid); end
        checks++;
        if (tx_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", tx_overflow); end
        addr = 32'hFFFF0008;
        #1;
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_status got=%08h exp=%08h", rdata, 32'h0); end
        reset = 1'b0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_cycle = 32'h0;
    endtask

    task automatic test_cycle();
        step(1'b0, 32'hFFFF0000, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'd0) begin failures++; $display("FAIL cycle0 got=%08h exp=%08h", s_rdata, 32'd0); end
        repeat (4) step(1'b0, 32'hFFFF000C, 32'h0, 1'b0);
        step(1'b0, 32'hFFFF0000, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'd5) begin failures++; $display("FAIL cycle5 got=%08h exp=%08h", s_rdata, 32'd5); end
        dut.cycle_reg = 32'hFFFFFFFF;
        m_cycle       = 32'hFFFFFFFF;
        step(1'b0, 32'hFFFF0000, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL cycle_max got=%08h exp=%08h", s_rdata, 32'hFFFFFFFF); end
        step(1'b0, 32'hFFFF0000, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h0) begin failures++; $display("FAIL cycle_wrap got=%08h exp=%08h", s_rdata, 32'h0); end
    endtask

    task automatic test_ram();
        step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        step(1'b0, 32'h10, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_read got=%08h exp=%08h", s_rdata, 32'hDEADBEEF); end
        step(1'b0, 32'h10 + (32'd4 << ADDR_W), 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_alias got=%08h exp=%08h", s_rdata, 32'hDEADBEEF); end
        step(1'b1, 32'h13, 32'h11111111, 1'b0);
        checks++;
        if (s_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_old_on_write got=%08h exp=%08h", s_rdata, 32'hDEADBEEF); end
        step(1'b0, 32'h10, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h11111111) begin failures++; $display("FAIL ram_new got=%08h exp=%08h", s_rdata, 32'h11111111); end
    endtask

    task automatic test_fifo_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'hFFFF0004, 32'(i), 1'b0);
            if (i == 1) begin
                checks++;
                if (s_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%0b exp=0", s_valid); end
            end
            if (i == 2) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== 32'd1) begin
                    failures++; $display("FAIL valid_after_push got=%0b/%08h exp=1/%08h", s_valid, s_data, 32'd1);
                end
            end
        end
        step(1'b0, 32'hFFFF0008, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h108) begin failures++; $display("FAIL status_full got=%08h exp=%08h", s_rdata, 32'h108); end
        step(1'b1, 32'hFFFF0004, 32'd9, 1'b0);
        step(1'b0, 32'hFFFF0008, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h308 || s_ovf !== 1'b1) begin
            failures++; $display("FAIL status_overflow got=%08h/%0b exp=%08h/1", s_rdata, s_ovf, 32'h308);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 32'hFFFF000C, 32'h0, 1'b1);
            checks++;
            if (s_valid !== 1'b1 || s_data !== 32'(i)) begin
                failures++; $display("FAIL drain_%0d got=%0b/%08h exp=1/%08h", i, s_valid, s_data, 32'(i));
            end
        end
        step(1'b0, 32'hFFFF000C, 32'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", s_valid); end
    endtask

    task automatic test_overflow_clear();
        step(1'b1, 32'hFFFF0008, 32'h0, 1'b0);
        step(1'b0, 32'hFFFF0008, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h200) begin failures++; $display("FAIL ovf_keep got=%08h exp=%08h", s_rdata, 32'h200); end
        step(1'b1, 32'hFFFF0008, 32'h200, 1'b0);
        step(1'b0, 32'hFFFF0008, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h0 || s_ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_clear got=%08h/%0b exp=%08h/0", s_rdata, s_ovf, 32'h0);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_words [8];
        for (int i = 0; i < 8; i++) step(1'b1, 32'hFFFF0004, 32'h10 + 32'(i), 1'b0);
        step(1'b1, 32'hFFFF0004, 32'hA5, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 32'h10) begin
            failures++; $display("FAIL fullpp_head got=%0b/%08h exp=1/%08h", s_valid, s_data, 32'h10);
        end
        step(1'b0, 32'hFFFF0008, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h108) begin failures++; $display("FAIL fullpp_status got=%08h exp=%08h", s_rdata, 32'h108); end
        for (int i = 0; i < 7; i++) exp_words[i] = 32'h11 + 32'(i);
        exp_words[7] = 32'hA5;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'hFFFF000C, 32'h0, 1'b1);
            checks++;
            if (s_valid !== 1'b1 || s_data !== exp_words[i]) begin
                failures++; $display("FAIL fullpp_drain_%0d got=%0b/%08h exp=1/%08h", i, s_valid, s_data, exp_words[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 1; i <= 3; i++) step(1'b1, 32'hFFFF0004, 32'h20 + 32'(i), 1'b0);
        step(1'b0, 32'hFFFF000C, 32'h0, 1'b1);
        checks++;
        if (s_data !== 32'h21) begin failures++; $display("FAIL mid_head got=%08h exp=%08h", s_data, 32'h21); end
        reset = 1'b1;
        addr  = 32'hFFFF0008;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL mid_reset got=%0b/%08h exp=0/%08h", tx_valid, rdata, 32'h0);
        end
        addr = 32'hFFFF0000;
        #1;
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL mid_reset_cycle got=%08h exp=%08h", rdata, 32'h0); end
        reset = 1'b0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_cycle = 32'h0;
        step(1'b0, 32'h10, 32'h0, 1'b0);
        checks++;
        if (s_rdata !== 32'h11111111 || s_valid !== 1'b0) begin
            failures++; $display("FAIL ram_kept got=%08h/%0b exp=%08h/0", s_rdata, s_valid, 32'h11111111);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        we, rdy;
        int          kind;
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i) << 2, $urandom, 1'b0);
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                a = (32'($urandom_range(0, 3)) << (ADDR_W + 2)) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
            end else begin
                a = 32'hFFFF0000 | (32'($urandom_range(0, 3)) << 2);
            end
            we  = ($urandom_range(0, 1) == 1);
            d   = $urandom;
            rdy = (n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(we, a, d, rdy);
            if (e_known) begin
                checks++;
                if (s_rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%08h exp=%08h", n, s_rdata, e_rdata); end
            end
            checks++;
            if (s_valid !== e_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, s_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if (s_data !== e_head) begin failures++; $display("FAIL rnd_data n=%0d got=%08h exp=%08h", n, s_data, e_head); end
            end
            checks++;
            if (s_ovf !== e_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%0b exp=%0b", n, s_ovf, e_ovf); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) m_known[i] = 1'b0;
        m_ovf    = 1'b0;
        m_cycle  = 32'h0;
        reset    = 1'b1;
        memwrite = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_cycle();
        test_ram();
        test_fifo_fill_drain();
        test_overflow_clear();
        test_full_push_pop();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
